sample_gain_drain: RTL and testbench
====================================

SAMPLE_GAIN_DRAIN -- requirements
Module: sample_gain_drain

Interface
REQ-001 Parameter DATA_SIZE, 32, sample width in bits (two's complement).
REQ-002 Parameter GAIN, 32'h00000400, signed DATA_SIZE-bit gain coefficient, fixed point with BITS fraction bits.
REQ-003 Parameter BITS, 10, number of fraction bits removed after the multiply.
REQ-004 Parameter SAMPLE_COUNT, 200, number of samples transferred per run.
REQ-005 clock  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a run.
REQ-008 in_empty  input  1  upstream first-word-fall-through FIFO empty; in_dout is valid when low.
REQ-009 in_rd_en  output  1  pops one upstream sample in the cycle it is high.
REQ-010 in_dout  input  DATA_SIZE  upstream sample (filter output stream).
REQ-011 out_full  input  1  downstream FIFO full.
REQ-012 out_wr_en  output  1  writes out_din to the downstream FIFO in the cycle it is high.
REQ-013 out_din  output  DATA_SIZE  scaled sample.
REQ-014 done  output  1  high once SAMPLE_COUNT samples have been written; held until next start.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE -> RUN when start=1; counters cleared on that edge.
REQ-017 RUN -> DONE on the edge where the write count reaches SAMPLE_COUNT.
REQ-018 DONE -> RUN when start=1; counters cleared, done deasserts on that edge.
REQ-019 start in RUN is ignored.
REQ-020 One-entry output register (result_q, valid_q); out_din = result_q; out_wr_en = valid_q & ~out_full.
REQ-021 in_rd_en = (state==RUN) & ~in_empty & (pop count < SAMPLE_COUNT) & (~valid_q | ~out_full).
REQ-022 On a pop: result_q <= (in_dout * GAIN) >>> BITS; valid_q <= 1.
REQ-023 Multiply at full 2*DATA_SIZE signed width; shift is arithmetic (floor toward minus infinity).
REQ-024 Pop and write in the same cycle: register reloads, valid_q stays 1; no bubble.
REQ-025 Write without pop: valid_q <= 0.
REQ-026 Latency: a sample popped at edge N is presented with out_wr_en high in cycle N+1 if out_full=0.
REQ-027 out_full high: result_q and valid_q hold; no pop; no sample lost or duplicated.
REQ-028 in_empty high: no pop; a pending valid_q sample still drains.
REQ-029 Exactly SAMPLE_COUNT pops and SAMPLE_COUNT writes per run; further upstream samples are left in the FIFO.
REQ-030 Counters sized $clog2(SAMPLE_COUNT+1); no wrap within a run.

Reset
REQ-031 reset=0 asynchronously forces state IDLE, counters 0, result_q 0, valid_q 0.
REQ-032 During and after reset: in_rd_en=0, out_wr_en=0, out_din=0, done=0.
REQ-033 Reset mid-RUN discards any held sample; the block waits for a new start.

Configuration
REQ-034 Macro SAMPLE_GAIN_SAT_EN defined: scaled value outside signed DATA_SIZE range clamps to 32'h7fffffff / 32'h80000000.
REQ-035 Macro undefined: scaled value is truncated to the low DATA_SIZE bits (wraps).

Verification
REQ-036 GAIN=0x400: in 0x00000123, 0xffffffff -> out 0x00000123, 0xffffffff, each one cycle after its pop.
REQ-037 GAIN=0x800: in 0x7fffffff -> out 0x7fffffff with SAMPLE_GAIN_SAT_EN, 0xfffffffe without.
REQ-038 GAIN=0x800, SAMPLE_COUNT=8, streaming input, out_full high for 5 cycles mid-run -> 8 writes, values 2x input, in order, none lost.
REQ-039 SAMPLE_COUNT=4, 6 samples queued upstream -> exactly 4 pops and 4 writes, done=1, 2 samples left in the FIFO; second start -> next 2 samples taken.
REQ-040 reset=0 asserted mid-run with valid_q=1 -> outputs 0 immediately; no write after release until start.

Source files
------------

// File: rtl/sample_gain_drain.sv
// Pops signed samples from an upstream FWFT FIFO, scales them by a fixed-point GAIN and writes
// exactly SAMPLE_COUNT results downstream per run. Define SAMPLE_GAIN_SAT_EN to clamp instead of wrap.
module sample_gain_drain #(
  parameter int                   DATA_SIZE    = 32,
  parameter logic [DATA_SIZE-1:0] GAIN         = 32'h00000400,
  parameter int                   BITS         = 10,
  parameter int                   SAMPLE_COUNT = 200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  input  logic [DATA_SIZE-1:0] in_dout,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [DATA_SIZE-1:0] out_din,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int             CW        = $clog2(SAMPLE_COUNT + 1);
  localparam int             PW        = 2 * DATA_SIZE;
  localparam logic [CW-1:0]  COUNT_MAX = CW'(SAMPLE_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [DATA_SIZE-1:0]   result_q, result_d;
  logic                   valid_q, valid_d;
  logic                   pop, wr;
  logic signed [PW-1:0]   sample_ext, gain_ext, product;
  logic [DATA_SIZE-1:0]   scaled;

  // Full-width signed product: a DATA_SIZE x DATA_SIZE signed multiply always fits in PW bits.
  always_comb begin
    sample_ext = PW'($signed(in_dout));
    gain_ext   = PW'($signed(GAIN));
    product    = sample_ext * gain_ext;
  end

`ifdef SAMPLE_GAIN_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX = $signed({{(DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN = $signed({{(DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}});
  logic signed [PW-1:0] shifted;

  always_comb begin
    shifted = product >>> BITS;
    if (shifted > SAT_MAX) begin
      scaled = {1'b0, {(DATA_SIZE-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      scaled = {1'b1, {(DATA_SIZE-1){1'b0}}};
    end else begin
      scaled = shifted[DATA_SIZE-1:0];
    end
  end
`else
  always_comb begin
    scaled = DATA_SIZE'(product >>> BITS);
  end
`endif

  // Handshake: a pop needs a free (or simultaneously draining) output slot; a write needs room downstream.
  always_comb begin
    pop       = (state_q == RUN) & ~in_empty & (pop_cnt_q < COUNT_MAX) & (~valid_q | ~out_full);
    wr        = valid_q & ~out_full;
    in_rd_en  = pop;
    out_wr_en = wr;
    out_din   = result_q;
    done      = (state_q == DONE);
    state_dbg = state_q;
  end

  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    result_d  = result_q;
    valid_d   = valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pop_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      RUN: begin
        if (pop) pop_cnt_d = pop_cnt_q + CW'(1);
        if (wr)  wr_cnt_d  = wr_cnt_q + CW'(1);
        if (wr_cnt_d == COUNT_MAX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      result_d = scaled;
      valid_d  = 1'b1;
    end else if (wr) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pop_cnt_q <= '0;
      wr_cnt_q  <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pop_cnt_q <= pop_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_sample_gain_drain.sv
// Bench for sample_gain_drain: upstream FIFO model, scoreboard of expected scaled samples,
// negedge monitor comparing every downstream write.
module tb_sample_gain_drain;

  localparam int          DS   = 32;
  localparam logic [31:0] GAIN = 32'h00000800;
  localparam int          BITS = 10;
  localparam int          SC   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_full = 1'b0;
  logic        in_empty, in_rd_en, out_wr_en, done;
  logic [31:0] in_dout, out_din;
  logic [1:0]  state_dbg;

  sample_gain_drain #(
    .DATA_SIZE(DS), .GAIN(GAIN), .BITS(BITS), .SAMPLE_COUNT(SC)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_empty(in_empty), .in_rd_en(in_rd_en), .in_dout(in_dout),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
    .done(done), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Upstream first-word-fall-through FIFO
  logic [31:0] fifo_mem [0:255];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic        pop_flag = 1'b0;
  int          cyc = 0;

  assign in_empty = (rd_ptr == wr_ptr);
  assign in_dout  = fifo_mem[rd_ptr[7:0]];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pop_flag) rd_ptr <= rd_ptr + 1;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  int          pop_cyc_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          pops = 0;
  int          writes = 0;
  bit          check_lat = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: floor(x * gain / 2^BITS), then clamp or keep the low 32 bits.
  function automatic logic [31:0] model(input logic [31:0] x);
    longint p, q, den;
    den = longint'(1) << BITS;
    p = longint'($signed(x)) * longint'($signed(GAIN));
    q = p / den;
    if (p < 0 && (p % den) != 0) q = q - 1;
`ifdef SAMPLE_GAIN_SAT_EN
    if (q > 64'sd2147483647)  return 32'h7fffffff;
    if (q < -64'sd2147483648) return 32'h80000000;
`endif
    return q[31:0];
  endfunction

  function automatic int level();
    return wr_ptr - rd_ptr;
  endfunction

  task automatic push_sample(input logic [31:0] v);
    fifo_mem[wr_ptr[7:0]] = v;
    wr_ptr++;
    exp_q.push_back(model(v));
  endtask

  always @(negedge clock) begin
    pop_flag = 1'b0;
    if (reset) begin
      if (in_rd_en) begin
        pop_flag = 1'b1;
        pops++;
        pop_cyc_q.push_back(cyc);
      end
      if (out_wr_en) begin
        writes++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got %h, expected no write", out_din);
        end else begin
          check("out_din", out_din, exp_q.pop_front());
        end
        if (pop_cyc_q.size() > 0) begin
          int pc;
          pc = pop_cyc_q.pop_front();
          if (check_lat) check("latency", 32'(cyc - pc), 32'd1);
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  // mode 0: no backpressure; 1: random backpressure; 2: 5-cycle stall plus an ignored start pulse
  task automatic run_to_done(input int mode, input string tag);
    int n = 0;
    while (n < 300) begin
      @(negedge clock);
      if (done) break;
      @(posedge clock); #1;
      case (mode)
        1:       out_full = ($urandom_range(0, 3) == 0);
        2: begin
          out_full = (n >= 3 && n < 8);
          start    = (n == 4);
        end
        default: out_full = 1'b0;
      endcase
      n++;
    end
    out_full = 1'b0;
    start    = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_and_check(input int mode, input string tag);
    int lvl, p0, w0;
    lvl = level(); p0 = pops; w0 = writes;
    pulse_start();
    run_to_done(mode, tag);
    #1;
    check({tag, "_pops"},   32'(pops - p0),   32'(SC));
    check({tag, "_writes"}, 32'(writes - w0), 32'(SC));
    check({tag, "_left"},   32'(level()),     32'(lvl - SC));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lvl, p0, w0, k;

    push_sample(32'h00000123);
    push_sample(32'hffffffff);
    push_sample(32'h7fffffff);
    push_sample(32'h80000000);
    for (int i = 0; i < 6; i++) push_sample($urandom);

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_rd_en",  {31'd0, in_rd_en},  32'd0);
    check("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("rst_out_din",   out_din,            32'd0);
    check("rst_done",      {31'd0, done},      32'd0);

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("idle_no_pop",   32'(pops),   32'd0);
    check("idle_no_write", 32'(writes), 32'd0);

    // Run A: streaming, checks one-cycle latency; 2 samples stay upstream
    check_lat = 1'b1;
    run_and_check(0, "runA");
    check_lat = 1'b0;
    p0 = pops;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("runA_done_held", {31'd0, done}, 32'd1);
    check("runA_no_extra",  32'(pops - p0), 32'd0);

    // Run B: restart from DONE, leftover samples first, 5-cycle stall, ignored start
    for (int i = 0; i < 9; i++) push_sample($urandom);
    run_and_check(2, "runB");

    // Run C: reset while a sample is held behind a full downstream FIFO
    for (int i = 0; i < 5; i++) push_sample($urandom_range(1, 32'h3fffffff));
    out_full = 1'b1;
    p0 = pops;
    pulse_start();
    k = 0;
    while (pops == p0 && k < 20) begin
      @(negedge clock); #1;
      k++;
    end
    check("runC_pop_seen", 32'(pops - p0), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    out_full = 1'b0;
    #1;
    check("midrst_in_rd_en",  {31'd0, in_rd_en},  32'd0);
    check("midrst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("midrst_out_din",   out_din,            32'd0);
    check("midrst_done",      {31'd0, done},      32'd0);
    repeat (pop_cyc_q.size()) void'(exp_q.pop_front());
    pop_cyc_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    lvl = level(); p0 = pops; w0 = writes;
    repeat (10) @(posedge clock);
    @(negedge clock); #1;
    check("postrst_no_write", 32'(writes - w0), 32'd0);
    check("postrst_no_pop",   32'(pops - p0),   32'd0);
    check("postrst_level",    32'(level()),     32'(lvl));
    check("postrst_done",     {31'd0, done},    32'd0);

    // Run D: fresh start after reset with random backpressure
    for (int i = 0; i < 4; i++) push_sample($urandom);
    run_and_check(1, "runD");

    check("leftover_match", 32'(exp_q.size()), 32'(level()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
